// File: rtl/pe_load_ctrl_pkg.sv
// pe_load_ctrl_pkg: shared types and width defaults for the PE-array load chain head-end
package pe_load_ctrl_pkg;

    localparam int ID_WIDTH_DEF      = 6;
    localparam int IN_DATA_WIDTH_DEF = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DRAIN = 3'd2,
        POP   = 3'd3,
        DONE  = 3'd4
    } load_state_e;

    typedef struct packed {
        logic                         vld;
        logic [ID_WIDTH_DEF-1:0]      id;
        logic [IN_DATA_WIDTH_DEF-1:0] data;
    } load_beat_t;

endpackage

// File: rtl/pe_load_ctrl.sv
// pe_load_ctrl: tags a weight stream with PE ids for the load chain, then issues a pop burst
module pe_load_ctrl
    import pe_load_ctrl_pkg::*;
#(
    parameter int ID_WIDTH      = ID_WIDTH_DEF,
    parameter int IN_DATA_WIDTH = IN_DATA_WIDTH_DEF,
    parameter int NUM_PE        = 64,
    parameter int WGT_DEPTH     = 4,
    parameter int DRAIN_CYCLES  = NUM_PE,
    parameter int POP_LEN_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    input  logic                     i_abort,
    input  logic [POP_LEN_WIDTH-1:0] i_pop_len,
    input  logic                     i_wgt_vld,
    output logic                     o_wgt_rdy,
    input  logic [IN_DATA_WIDTH-1:0] i_wgt_data,
    output logic                     o_load_vld,
    output logic [ID_WIDTH-1:0]      o_load_id,
    output logic [IN_DATA_WIDTH-1:0] o_load_data,
    output logic                     o_pop_vld,
    output logic                     o_busy,
    output logic                     o_done
);

    localparam int SW = (WGT_DEPTH > 1) ? $clog2(WGT_DEPTH) : 1;
    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    load_state_e              state;
    logic [ID_WIDTH-1:0]      id_cnt;
    logic [SW-1:0]            slot_cnt;
    logic [DW-1:0]            drain_cnt;
    logic [POP_LEN_WIDTH-1:0] pop_len_r;
    logic [POP_LEN_WIDTH-1:0] pop_cnt;

    assign o_wgt_rdy = (state == LOAD);
    assign o_busy    = (state != IDLE);

    // Sequence FSM with its counters; all chain-facing outputs are registered here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            id_cnt      <= '0;
            slot_cnt    <= '0;
            drain_cnt   <= '0;
            pop_len_r   <= '0;
            pop_cnt     <= '0;
            o_load_vld  <= 1'b0;
            o_load_id   <= '0;
            o_load_data <= '0;
            o_pop_vld   <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            o_load_vld <= 1'b0;
            o_pop_vld  <= 1'b0;
            o_done     <= 1'b0;
            if (i_abort) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (i_start) begin
                        pop_len_r <= i_pop_len;
                        id_cnt    <= '0;
                        slot_cnt  <= '0;
                        state     <= LOAD;
                    end
                    LOAD: if (i_wgt_vld) begin
                        o_load_vld  <= 1'b1;
                        o_load_id   <= id_cnt;
                        o_load_data <= i_wgt_data;
                        if (slot_cnt == SW'(WGT_DEPTH - 1)) begin
                            slot_cnt <= '0;
                            if (id_cnt == ID_WIDTH'(NUM_PE - 1)) begin
                                drain_cnt <= DW'(DRAIN_CYCLES - 1);
                                state     <= DRAIN;
                            end else begin
                                id_cnt <= id_cnt + 1'b1;
                            end
                        end else begin
                            slot_cnt <= slot_cnt + 1'b1;
                        end
                    end
                    DRAIN: if (drain_cnt == '0) begin
                        if (pop_len_r != '0) begin
                            pop_cnt <= pop_len_r;
                            state   <= POP;
                        end else begin
                            o_done <= 1'b1;
                            state  <= DONE;
                        end
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                    POP: begin
                        o_pop_vld <= 1'b1;
                        pop_cnt   <= pop_cnt - 1'b1;
                        if (pop_cnt == POP_LEN_WIDTH'(1)) begin
                            o_done <= 1'b1;
                            state  <= DONE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pe_load_ctrl.sv
// tb_pe_load_ctrl: directed checks of load tagging, stalls, drain, pop burst, abort and reset
module tb_pe_load_ctrl;

    localparam int IW = 6;
    localparam int DWD = 8;
    localparam int PLW = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           i_start = 1'b0;
    logic           i_abort = 1'b0;
    logic [PLW-1:0] i_pop_len = '0;
    logic           i_wgt_vld = 1'b0;
    logic           o_wgt_rdy;
    logic [DWD-1:0] i_wgt_data = '0;
    logic           o_load_vld;
    logic [IW-1:0]  o_load_id;
    logic [DWD-1:0] o_load_data;
    logic           o_pop_vld;
    logic           o_busy;
    logic           o_done;

    int total = 0;
    int bad = 0;

    pe_load_ctrl #(
        .ID_WIDTH(IW), .IN_DATA_WIDTH(DWD), .NUM_PE(4), .WGT_DEPTH(2),
        .DRAIN_CYCLES(4), .POP_LEN_WIDTH(PLW)
    ) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
        .i_pop_len(i_pop_len), .i_wgt_vld(i_wgt_vld), .o_wgt_rdy(o_wgt_rdy),
        .i_wgt_data(i_wgt_data), .o_load_vld(o_load_vld), .o_load_id(o_load_id),
        .o_load_data(o_load_data), .o_pop_vld(o_pop_vld), .o_busy(o_busy),
        .o_done(o_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [PLW-1:0] len);
        i_wgt_vld = 1'b0;
        i_pop_len = len;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("start_busy", o_busy, 1);
        chk("start_rdy", o_wgt_rdy, 1);
        chk("start_lvld", o_load_vld, 0);
    endtask

    task automatic load_all(input logic [7:0] base, input bit stall);
        int k = 0;
        bit ph = 1'b0;
        logic sent;
        while (k < 8) begin
            sent = stall ? ~ph : 1'b1;
            ph = ~ph;
            i_wgt_vld = sent;
            i_wgt_data = base + 8'(k);
            tick();
            chk("load_vld", o_load_vld, sent);
            if (sent) begin
                chk("load_id", o_load_id, k / 2);
                chk("load_data", o_load_data, base + 8'(k));
                k++;
            end
        end
        i_wgt_vld = 1'b0;
        chk("rdy_after_last", o_wgt_rdy, 0);
    endtask

    task automatic idle_drain();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("drain_lvld", o_load_vld, 0);
            chk("drain_pop", o_pop_vld, 0);
            chk("drain_done", o_done, 0);
        end
        tick();
        chk("drain4_lvld", o_load_vld, 0);
        chk("drain4_pop", o_pop_vld, 0);
    endtask

    initial begin
        #3;
        chk("rst_lvld", o_load_vld, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_pop", o_pop_vld, 0);
        chk("rst_rdy", o_wgt_rdy, 0);
        #9 rst = 1'b0;
        tick();

        // nominal run, pop_len=3
        start(8'd3);
        load_all(8'h10, 1'b0);
        idle_drain();
        chk("nom_done_pre", o_done, 0);
        tick(); chk("nom_pop1", o_pop_vld, 1);
        tick(); chk("nom_pop2", o_pop_vld, 1); chk("nom_done0", o_done, 0);
        tick(); chk("nom_pop3", o_pop_vld, 1); chk("nom_done", o_done, 1); chk("nom_busy", o_busy, 1);
        tick(); chk("nom_pop_end", o_pop_vld, 0); chk("nom_done_end", o_done, 0); chk("nom_idle", o_busy, 0);

        // stalled source with pop_len=0: drain goes straight to done
        start(8'd0);
        load_all(8'h40, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("z_pop", o_pop_vld, 0);
            chk("z_done_early", o_done, 0);
        end
        tick(); chk("z_done", o_done, 1); chk("z_pop4", o_pop_vld, 0); chk("z_busy", o_busy, 1);
        tick(); chk("z_done_end", o_done, 0); chk("z_pop5", o_pop_vld, 0); chk("z_idle", o_busy, 0);

        // abort after third accepted word; a word handshaken in the abort cycle is dropped
        start(8'd2);
        for (int k = 0; k < 3; k++) begin
            i_wgt_vld = 1'b1;
            i_wgt_data = 8'h20 + 8'(k);
            tick();
            chk("ab_id", o_load_id, k / 2);
            chk("ab_data", o_load_data, 8'h20 + 8'(k));
        end
        i_abort = 1'b1;
        i_wgt_data = 8'h23;
        tick();
        i_abort = 1'b0;
        i_wgt_vld = 1'b0;
        chk("ab_lvld", o_load_vld, 0);
        chk("ab_rdy", o_wgt_rdy, 0);
        chk("ab_busy", o_busy, 0);
        chk("ab_done", o_done, 0);
        tick();
        chk("ab_done2", o_done, 0);

        // restart reloads from id 0; start during POP is ignored
        start(8'd2);
        load_all(8'h30, 1'b0);
        idle_drain();
        i_start = 1'b1;
        i_pop_len = 8'd7;
        tick(); chk("ig_pop1", o_pop_vld, 1); chk("ig_done0", o_done, 0);
        tick(); chk("ig_pop2", o_pop_vld, 1); chk("ig_done", o_done, 1);
        i_start = 1'b0;
        tick(); chk("ig_pop_end", o_pop_vld, 0); chk("ig_idle", o_busy, 0);
        tick(); chk("ig_pop_after", o_pop_vld, 0);

        // async reset in DRAIN while the last chain word is still on the outputs
        start(8'd5);
        load_all(8'h50, 1'b0);
        chk("pre_rst_lvld", o_load_vld, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_lvld", o_load_vld, 0);
        chk("arst_id", o_load_id, 0);
        chk("arst_data", o_load_data, 0);
        chk("arst_busy", o_busy, 0);
        chk("arst_rdy", o_wgt_rdy, 0);
        #3 rst = 1'b0;
        tick();
        tick();
        chk("post_rst_rdy", o_wgt_rdy, 0);
        chk("post_rst_busy", o_busy, 0);
        chk("post_rst_pop", o_pop_vld, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: sim did not finish");
        $fatal(1, "timeout");
    end

endmodule
